// File: rtl/decode_queue.sv
// Two-entry instruction queue with a combinational RV32I field/immediate decode of the head entry.
// Latency: one cycle from an accepted push to the head; an empty queue never passes input straight through.
// Backpressure: ready_o is a flop and drops when both entries are full; ready_i stalls the head in place.
module decode_queue #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

    logic [1:0]        count_q, count_d;
    logic              rptr_q, rptr_d;
    logic              wptr_q, wptr_d;
    logic              ready_q, ready_d;
    logic [AWIDTH-1:0] pc_mem_q   [2];
    logic [AWIDTH-1:0] pc_mem_d   [2];
    logic [DWIDTH-1:0] insn_mem_q [2];
    logic [DWIDTH-1:0] insn_mem_d [2];

    logic push, pop;

    assign valid_o = (count_q != 2'd0);
    assign ready_o = ready_q;
    assign push    = valid_i && ready_q;
    assign pop     = valid_o && ready_i;

    // Next-state for pointers, occupancy, storage and the registered ready; flush wins over push/pop.
    always_comb begin
        count_d    = count_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        pc_mem_d   = pc_mem_q;
        insn_mem_d = insn_mem_q;
        if (flush_i) begin
            count_d = 2'd0;
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
        end else begin
            if (push) begin
                pc_mem_d[wptr_q]   = pc_i;
                insn_mem_d[wptr_q] = insn_i;
                wptr_d             = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        // ready is held low through reset and only rises at the first edge afterwards
        ready_d = (count_d < 2'd2);
    end

    // State registers; reset empties the queue and parks NOPs in storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 2'd0;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem_q[i]   <= '0;
                insn_mem_q[i] <= NOP;
            end
        end else begin
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            ready_q    <= ready_d;
            pc_mem_q   <= pc_mem_d;
            insn_mem_q <= insn_mem_d;
        end
    end

    // Head selection: an empty queue presents PC 0 and a NOP so downstream decode stays benign.
    always_comb begin
        pc_o   = '0;
        insn_o = NOP;
        if (count_q != 2'd0) begin
            pc_o   = pc_mem_q[rptr_q];
            insn_o = insn_mem_q[rptr_q];
        end
    end

    logic [31:0] hi;
    logic [31:0] imm32;
    logic        legal;

    assign hi       = insn_o[31:0];
    assign opcode_o = hi[6:0];
    assign rd_o     = hi[11:7];
    assign funct3_o = hi[14:12];
    assign rs1_o    = hi[19:15];
    assign rs2_o    = hi[24:20];
    assign funct7_o = hi[31:25];

    // Immediate reconstruction by instruction format, plus the RV32I base-opcode legality check.
    always_comb begin
        imm32 = 32'h0;
        legal = 1'b0;
        case (hi[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
                imm32 = {{20{hi[31]}}, hi[31:20]};
            7'b0100011:
                imm32 = {{20{hi[31]}}, hi[31:25], hi[11:7]};
            7'b1100011:
                imm32 = {{19{hi[31]}}, hi[31], hi[7], hi[30:25], hi[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {hi[31:12], 12'h000};
            7'b1101111:
                imm32 = {{11{hi[31]}}, hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
            default:
                imm32 = 32'h0;
        endcase
        case (hi[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111:
                legal = 1'b1;
            default:
                legal = 1'b0;
        endcase
    end

    assign imm_o     = DWIDTH'($signed(imm32));
    assign illegal_o = valid_o && !legal;

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction width.
REQ-002 SHALL have parameter AWIDTH, default 32, PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i  input  1  fetch offers pc_i/insn_i.
REQ-006 SHALL have port pc_i  input  AWIDTH  PC of offered instruction.
REQ-007 SHALL have port insn_i  input  DWIDTH  offered instruction word.
REQ-008 SHALL have port ready_o  output  1  queue can accept an instruction this cycle.
REQ-009 SHALL have port flush_i  input  1  discard all queued entries (redirect).
REQ-010 SHALL have port ready_i  input  1  downstream accepts head entry.
REQ-011 SHALL have port valid_o  output  1  head entry valid.
REQ-012 SHALL have port pc_o  output  AWIDTH  head PC.
REQ-013 SHALL have port insn_o  output  DWIDTH  head instruction.
REQ-014 SHALL have ports opcode_o[6:0], rd_o[4:0], rs1_o[4:0], rs2_o[4:0], funct3_o[2:0], funct7_o[6:0], all outputs, as head-instruction fields.
REQ-015 SHALL have port imm_o  output  DWIDTH  sign-extended immediate of head.
REQ-016 SHALL have port illegal_o  output  1  head opcode not RV32I.

Function
REQ-017 SHALL be a 2-entry FIFO of {pc, insn} with 1-bit wrapping read/write pointers and a 2-bit count in 0..2.
REQ-018 SHALL accept (push) when valid_i && ready_o, and complete (pop) when valid_o && ready_i.
REQ-019 SHALL drive ready_o = (count < 2) from registered state only; no combinational path from ready_i or valid_i to ready_o.
REQ-020 SHALL drive valid_o = (count != 0), registered state only.
REQ-021 SHALL have a latency of exactly 1 cycle: an entry pushed in cycle N appears at the head no earlier than cycle N+1, with no fall-through when empty.
REQ-022 SHALL, on simultaneous push and pop at count 1, keep count 1 and present the pushed entry at the head next cycle.
REQ-023 SHALL, at count 2, refuse the push (ready_o low), and on pop drop count to 1.
REQ-024 SHALL preserve FIFO order across pointer wrap-around.
REQ-025 SHALL, when flush_i is high, set count 0 and both pointers 0 at the clock edge; a push or pop in the same cycle is discarded; flush overrides all.
REQ-026 SHALL, when count == 0, drive pc_o = 0 and insn_o = 0x00000013 (NOP).
REQ-027 SHALL decode combinationally from insn_o: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-028 SHALL produce imm_o for I-type (0010011, 0000011, 1100111, 1110011) as sext(insn[31:20]).
REQ-029 SHALL produce imm_o for S-type (0100011) as sext({insn[31:25],insn[11:7]}).
REQ-030 SHALL produce imm_o for B-type (1100011) as sext({insn[31],insn[7],insn[30:25],insn[11:8],1'b0}).
REQ-031 SHALL produce imm_o for U-type (0110111, 0010111) as {insn[31:12],12'b0}, and for J-type (1101111) as sext({insn[31],insn[19:12],insn[20],insn[30:21],1'b0}).
REQ-032 SHALL drive imm_o = 0 for any other opcode.
REQ-033 SHALL drive illegal_o = valid_o && opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111}.

Reset
REQ-034 SHALL, while rst == 0, asynchronously clear count and pointers and clear storage to {pc 0, insn 0x00000013}.
REQ-035 SHALL hold valid_o = 0, ready_o = 0 and illegal_o = 0 during reset, with ready_o = 1 from the first edge after release.
REQ-036 SHALL, on reset asserted mid-transfer, lose all entries; pc_o = 0 and insn_o = 0x00000013 immediately, with no clock needed.

Verification
REQ-037 SHALL pass: push {0x01000000, 0x00500093} with ready_i = 0 -> next cycle valid_o = 1, rd_o = 1, imm_o = 5, ready_o = 1.
REQ-038 SHALL pass: three back-to-back pushes with ready_i = 0 -> third refused (ready_o = 0 after 2), then pops return entries 1 and 2 in order.
REQ-039 SHALL pass: continuous valid_i/ready_i for 6 instructions -> 6 pops in order across 3 pointer wraps, count steady at 1.
REQ-040 SHALL pass: count 2, flush_i with valid_i = 1 -> next cycle valid_o = 0, ready_o = 1, pc_o = 0, insn_o = 0x00000013.
REQ-041 SHALL pass: head insn 0xFE000EE3 (beq x0,x0,-4) -> imm_o = 0xFFFFFFFC; head 0xFFFFFFFF -> illegal_o = 1.
REQ-042 SHALL pass: rst driven low between clock edges at count 1 -> valid_o = 0 immediately.
